// File: rtl/mgr_oob_tx.sv
// Stack Bus OOB downstream transmitter: turns one configuration command plus its option
// words into a delimited OOB packet (header + N payload words) behind a valid/ready stage.
module mgr_oob_tx #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned LANES_W = 6,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TYPE_W  = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_poweron,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [TAG_W-1:0]   cmd_tag,
    input  logic [LANES_W-1:0] cmd_num_lanes,
    input  logic [LEN_W-1:0]   cmd_num_words,
    input  logic               pl_valid,
    output logic               pl_ready,
    input  logic [DATA_W-1:0]  pl_data,
    output logic               mgr__std__oob_valid,
    input  logic               std__mgr__oob_ready,
    output logic [1:0]         mgr__std__oob_cntl,
    output logic [TYPE_W-1:0]  mgr__std__oob_type,
    output logic [DATA_W-1:0]  mgr__std__oob_data,
    output logic               busy,
    output logic [CNT_W-1:0]   pkt_count
);

    localparam logic [1:0] CNTL_SOM_EOM = 2'b00;
    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_MOM     = 2'b10;
    localparam logic [1:0] CNTL_EOM     = 2'b11;

    localparam logic [TYPE_W-1:0] TYPE_HDR = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] TYPE_OPT = TYPE_W'(2);

    typedef enum logic {StIdle, StPayload} state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   rem_q;
    logic               free;
    logic               last_accepted;
    logic [DATA_W-1:0]  hdr_data;

    // Output register may take a new word when empty or draining this cycle.
    assign free = !mgr__std__oob_valid || std__mgr__oob_ready;

    // Gated with reset so every output reads 0 while reset is held.
    assign cmd_ready = reset_poweron && (state_q == StIdle) && free;
    assign pl_ready  = (state_q == StPayload) && free;
    assign busy      = (state_q == StPayload) || mgr__std__oob_valid;

    assign last_accepted = mgr__std__oob_valid && std__mgr__oob_ready &&
                           ((mgr__std__oob_cntl == CNTL_EOM) ||
                            (mgr__std__oob_cntl == CNTL_SOM_EOM));

    always_comb begin
        hdr_data = '0;
        hdr_data[TAG_W-1:0]                = cmd_tag;
        hdr_data[TAG_W +: LANES_W]         = cmd_num_lanes;
        hdr_data[TAG_W + LANES_W +: LEN_W] = cmd_num_words;
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q             <= StIdle;
            rem_q               <= '0;
            mgr__std__oob_valid <= 1'b0;
            mgr__std__oob_cntl  <= 2'b00;
            mgr__std__oob_type  <= '0;
            mgr__std__oob_data  <= '0;
        end else if (free) begin
            // Fields keep their last value when nothing new loads; only valid drops.
            mgr__std__oob_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        mgr__std__oob_valid <= 1'b1;
                        mgr__std__oob_type  <= TYPE_HDR;
                        mgr__std__oob_data  <= hdr_data;
                        rem_q               <= cmd_num_words;
                        if (cmd_num_words == '0) begin
                            mgr__std__oob_cntl <= CNTL_SOM_EOM;
                        end else begin
                            mgr__std__oob_cntl <= CNTL_SOM;
                            state_q            <= StPayload;
                        end
                    end
                end
                StPayload: begin
                    if (pl_valid) begin
                        mgr__std__oob_valid <= 1'b1;
                        mgr__std__oob_type  <= TYPE_OPT;
                        mgr__std__oob_data  <= pl_data;
                        rem_q               <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            mgr__std__oob_cntl <= CNTL_EOM;
                            state_q            <= StIdle;
                        end else begin
                            mgr__std__oob_cntl <= CNTL_MOM;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            pkt_count <= '0;
        end else if (last_accepted) begin
            pkt_count <= pkt_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mgr_oob_tx.sv
// Bench for mgr_oob_tx: directed vector table, hand sequences for reset/back-to-back/wrap,
// and randomized packets checked word-by-word against an expected-word queue.
module tb_mgr_oob_tx;

    logic        clk = 1'b0;
    logic        reset_poweron;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_tag;
    logic [5:0]  cmd_num_lanes;
    logic [3:0]  cmd_num_words;
    logic        pl_valid;
    logic        pl_ready;
    logic [31:0] pl_data;
    logic        oob_valid;
    logic        oob_ready;
    logic [1:0]  oob_cntl;
    logic [1:0]  oob_type;
    logic [31:0] oob_data;
    logic        busy;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    mgr_oob_tx dut (
        .clk                 (clk),
        .reset_poweron       (reset_poweron),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_tag             (cmd_tag),
        .cmd_num_lanes       (cmd_num_lanes),
        .cmd_num_words       (cmd_num_words),
        .pl_valid            (pl_valid),
        .pl_ready            (pl_ready),
        .pl_data             (pl_data),
        .mgr__std__oob_valid (oob_valid),
        .std__mgr__oob_ready (oob_ready),
        .mgr__std__oob_cntl  (oob_cntl),
        .mgr__std__oob_type  (oob_type),
        .mgr__std__oob_data  (oob_data),
        .busy                (busy),
        .pkt_count           (pkt_count)
    );

    typedef struct packed {
        logic [1:0]  cntl;
        logic [1:0]  typ;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic [7:0]  tag;
        logic [5:0]  lanes;
        logic [3:0]  words;
        logic [31:0] exp_hdr;
        int          rdy_mode;
    } vec_t;

    int    total = 0;
    int    bad = 0;
    int    model_pkts = 0;
    int    cyc = 0;
    int    rdy_mode = 0;
    word_t exp_q[$];
    int    acc_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Ready pattern 1,0,0,1,0,1 repeating in mode 1; random in mode 2.
    initial begin
        logic [5:0] pat;
        int idx;
        pat = 6'b101001;
        idx = 0;
        oob_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: oob_ready = 1'b1;
                1: begin
                    oob_ready = pat[idx];
                    idx = (idx + 1) % 6;
                end
                default: oob_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    // Monitor: every accepted word must be the next expected one; stalled words must hold.
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [35:0] prev_w = '0;
    always @(negedge clk) begin
        word_t cur;
        word_t e;
        cyc++;
        cur = {oob_cntl, oob_type, oob_data};
        if (!reset_poweron) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("stall_valid", 64'(oob_valid), 64'd1);
                check("stall_word", 64'(cur), 64'(prev_w));
            end
            if (oob_valid && !oob_ready) begin
                check("pl_ready_when_full", 64'(pl_ready), 64'd0);
                check("cmd_ready_when_full", 64'(cmd_ready), 64'd0);
            end
            if (oob_valid && oob_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h want no word", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 64'(cur), 64'(e));
                    if (e.cntl == 2'b00 || e.cntl == 2'b11) model_pkts++;
                    acc_cyc.push_back(cyc);
                end
            end
            prev_v = oob_valid;
            prev_r = oob_ready;
            prev_w = cur;
        end
    end

    task automatic wait_acc(input bit is_pl, input string name);
        int t;
        bit acc;
        t = 0;
        do begin
            @(negedge clk);
            acc = is_pl ? pl_ready : cmd_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 300);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL %s: got no accept in 300 cycles want accept", name);
        end
    endtask

    task automatic send_pkt(input logic [7:0] tag, input logic [5:0] lanes,
                            input logic [3:0] n, input logic [31:0] hdr,
                            input bit bubbles, input bit rnd_data);
        logic [31:0] pl[16];
        word_t w;
        w.cntl = (n == 0) ? 2'b00 : 2'b01;
        w.typ  = 2'b01;
        w.data = hdr;
        exp_q.push_back(w);
        for (int i = 0; i < int'(n); i++) begin
            pl[i]  = rnd_data ? $urandom : 32'hA0 + 32'(i);
            w.cntl = (i == int'(n) - 1) ? 2'b11 : 2'b10;
            w.typ  = 2'b10;
            w.data = pl[i];
            exp_q.push_back(w);
        end
        cmd_valid = 1'b1;
        cmd_tag = tag;
        cmd_num_lanes = lanes;
        cmd_num_words = n;
        wait_acc(1'b0, "cmd_accept");
        cmd_valid = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            if (bubbles && ($urandom % 3) == 0) begin
                pl_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            pl_valid = 1'b1;
            pl_data = pl[i];
            wait_acc(1'b1, "pl_accept");
        end
        pl_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || oob_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("pkt_count", 64'(pkt_count), 64'(model_pkts % 65536));
        check("busy_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_poweron = 1'b0;
        cmd_valid = 1'b0;
        pl_valid = 1'b0;
        exp_q.delete();
        model_pkts = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_poweron = 1'b1;
    endtask

    vec_t vecs[5];

    initial begin
        int k;
        logic [7:0]  tag;
        logic [5:0]  lanes;
        logic [3:0]  n;
        word_t w;

        vecs[0] = '{8'h5A, 6'd32, 4'd0,  32'h0000_205A, 0};
        vecs[1] = '{8'h11, 6'd4,  4'd3,  32'h0000_C411, 0};
        vecs[2] = '{8'h11, 6'd4,  4'd3,  32'h0000_C411, 1};
        vecs[3] = '{8'hFF, 6'd63, 4'd15, 32'h0003_FFFF, 2};
        vecs[4] = '{8'h00, 6'd0,  4'd1,  32'h0000_4000, 1};

        reset_poweron = 1'b0;
        cmd_valid = 1'b0;
        cmd_tag = '0;
        cmd_num_lanes = '0;
        cmd_num_words = '0;
        pl_valid = 1'b0;
        pl_data = '0;
        #2;
        check("rst_valid", 64'(oob_valid), 64'd0);
        check("rst_word", 64'({oob_cntl, oob_type, oob_data}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(pkt_count), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_pl_ready", 64'(pl_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_poweron = 1'b1;

        // Single-word packet: busy for exactly one cycle, then count = 1.
        rdy_mode = 0;
        send_pkt(8'h5A, 6'd32, 4'd0, 32'h0000_205A, 1'b0, 1'b0);
        @(negedge clk);
        check("sw_busy_hi", 64'({busy, oob_valid}), 64'b11);
        @(negedge clk);
        check("sw_busy_lo", 64'(busy), 64'd0);
        check("sw_count", 64'(pkt_count), 64'd1);

        // Option words are ignored in IDLE.
        @(posedge clk);
        #1;
        pl_valid = 1'b1;
        @(negedge clk);
        check("idle_pl_ready", 64'(pl_ready), 64'd0);
        @(negedge clk);
        check("idle_pl_ignored", 64'(oob_valid), 64'd0);
        @(posedge clk);
        #1;
        pl_valid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            rdy_mode = vecs[i].rdy_mode;
            send_pkt(vecs[i].tag, vecs[i].lanes, vecs[i].words, vecs[i].exp_hdr, 1'b0, 1'b0);
            drain();
        end

        // Back-to-back packets with ready high: four words on four consecutive cycles.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        k = acc_cyc.size();
        send_pkt(8'h21, 6'd2, 4'd2, 32'h0000_8221, 1'b0, 1'b0);
        send_pkt(8'h22, 6'd3, 4'd0, 32'h0000_0322, 1'b0, 1'b0);
        drain();
        check("b2b_words", 64'(acc_cyc.size() - k), 64'd4);
        for (int i = 1; i < 4; i++) begin
            if (acc_cyc.size() >= k + 4)
                check("b2b_gap", 64'(acc_cyc[k + i] - acc_cyc[k + i - 1]), 64'd1);
        end

        // Reset mid-payload, after the second of four option words has loaded.
        rdy_mode = 0;
        w = '{2'b01, 2'b01, 32'h0001_0533};
        exp_q.push_back(w);
        for (int i = 0; i < 4; i++) exp_q.push_back('{(i == 3) ? 2'b11 : 2'b10, 2'b10,
                                                     32'hB0 + 32'(i)});
        cmd_valid = 1'b1;
        cmd_tag = 8'h33;
        cmd_num_lanes = 6'd5;
        cmd_num_words = 4'd4;
        wait_acc(1'b0, "rst_cmd_accept");
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pl_valid = 1'b1;
            pl_data = 32'hB0 + 32'(i);
            wait_acc(1'b1, "rst_pl_accept");
        end
        check("pre_rst_valid", 64'(oob_valid), 64'd1);
        #1;
        reset_poweron = 1'b0;
        #1;
        check("mid_rst_valid", 64'(oob_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_count", 64'(pkt_count), 64'd0);
        check("mid_rst_pl_ready", 64'(pl_ready), 64'd0);
        exp_q.delete();
        model_pkts = 0;
        pl_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_poweron = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_rst_pl_ready", 64'(pl_ready), 64'd0);
        @(posedge clk);
        #1;
        send_pkt(8'h44, 6'd1, 4'd2, 32'h0000_8144, 1'b0, 1'b0);
        drain();

        // Random packets in groups of five, ready mode fixed per group.
        for (int g = 0; g < 10; g++) begin
            rdy_mode = int'($urandom % 3);
            for (int p = 0; p < 5; p++) begin
                tag   = 8'($urandom);
                lanes = 6'($urandom);
                n     = 4'($urandom % 16);
                send_pkt(tag, lanes, n,
                         32'(tag) + 32'(lanes) * 256 + 32'(n) * 16384, 1'b1, 1'b1);
            end
            drain();
        end

        // Counter wrap: 65535 one-word packets reach 0xFFFF, one more wraps to 0.
        rdy_mode = 0;
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            send_pkt(8'(i), 6'd0, 4'd0, 32'(i % 256), 1'b0, 1'b0);
        end
        drain();
        check("wrap_ffff", 64'(pkt_count), 64'h0000_FFFF);
        send_pkt(8'h77, 6'd7, 4'd0, 32'h0000_0777, 1'b0, 1'b0);
        drain();
        check("wrap_zero", 64'(pkt_count), 64'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
